hci_mem_req_spill: RTL and testbench

Two-entry spill buffer on the HCI memory request path, placed directly upstream of the plain memory assignment/pass-through stage feeding a TCDM bank. It registers every request field and the upstream grant, which breaks the combinational `gnt` path between interconnect and memory while sustaining one transaction per cycle. It also produces an explicit response-valid strobe for the upstream initiator, derived from the downstream handshake and the memory's fixed one-cycle read latency.

---
 rtl/hci_mem_req_spill_if.sv | 33 +++
 rtl/hci_mem_req_spill.sv | 100 ++++++++++
 tb/tb_hci_mem_req_spill.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_mem_req_spill_if.sv
// HCI TCDM request/response bundle shared by the
// interconnect side and the memory side.
interface hci_mem_intf #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned IW = 8,
  parameter int unsigned UW = 1
);
  localparam int unsigned BEW = DW / BW;

  logic           req;
  logic           gnt;
  logic [AW-1:0]  add;
  logic           wen;
  logic [DW-1:0]  data;
  logic [BEW-1:0] be;
  logic [IW-1:0]  id;
  logic [UW-1:0]  user;
  logic [DW-1:0]  r_data;
  logic [IW-1:0]  r_id;
  logic [UW-1:0]  r_user;

  modport initiator (
    output req, add, wen, data, be, id, user,
    input  gnt, r_data, r_id, r_user
  );

  modport target (
    input  req, add, wen, data, be, id, user,
    output gnt, r_data, r_id, r_user
  );
endinterface

// File: rtl/hci_mem_req_spill.sv
// Two-entry spill buffer on the HCI request path;
// registers fields and grant, emits a response strobe.
module hci_mem_req_spill #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned IW = 8,
  parameter int unsigned UW = 1
) (
  input  logic           clk_i,
  input  logic           clear_i,
  hci_mem_intf.target    tcdm_target,
  output logic           tcdm_r_valid_o,
  hci_mem_intf.initiator tcdm_initiator,
  output logic [1:0]     occupancy_o
);
  localparam int unsigned BEW = DW / BW;

  typedef struct packed {
    logic [AW-1:0]  add;
    logic           wen;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
    logic [IW-1:0]  id;
    logic [UW-1:0]  user;
  } entry_t;

  entry_t     ent_q [2];
  entry_t     wr_ent;
  entry_t     head;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       r_valid_q;
  logic       up_gnt;
  logic       dn_req;
  logic       push;
  logic       pop;

  // Grant depends on the count register only.
  assign up_gnt = ~cnt_q[1];
  assign dn_req = |cnt_q;
  assign push   = tcdm_target.req & up_gnt;
  assign pop    = dn_req & tcdm_initiator.gnt;

  assign wr_ent = '{
    add:  tcdm_target.add,
    wen:  tcdm_target.wen,
    data: tcdm_target.data,
    be:   tcdm_target.be,
    id:   tcdm_target.id,
    user: tcdm_target.user
  };

  assign head = ent_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 2'd1;
      pop && !push: cnt_d = cnt_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      r_valid_q <= pop;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ent_q[wr_ptr_q] <= wr_ent;
  end

  assign tcdm_target.gnt    = up_gnt;
  assign tcdm_target.r_data = tcdm_initiator.r_data;
  assign tcdm_target.r_id   = tcdm_initiator.r_id;
  assign tcdm_target.r_user = tcdm_initiator.r_user;

  assign tcdm_initiator.req  = dn_req;
  assign tcdm_initiator.add  = head.add;
  assign tcdm_initiator.wen  = head.wen;
  assign tcdm_initiator.data = head.data;
  assign tcdm_initiator.be   = head.be;
  assign tcdm_initiator.id   = head.id;
  assign tcdm_initiator.user = head.user;

  assign tcdm_r_valid_o = r_valid_q;
  assign occupancy_o    = cnt_q;
endmodule

// File: tb/tb_hci_mem_req_spill.sv
// Directed bench for hci_mem_req_spill with a
// request/response scoreboard and a 1-cycle memory model.
module tb_hci_mem_req_spill;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int IW = 8;
  localparam int UW = 1;

  typedef struct packed {
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW-1:0]    data;
    logic [DW/BW-1:0] be;
    logic [IW-1:0]    id;
    logic [UW-1:0]    user;
  } req_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       mem_gnt;
  logic       r_valid;
  logic [1:0] occ;
  logic       exp_rv = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  req_t       req_q[$];
  req_t       resp_q[$];

  hci_mem_intf #(.AW(AW), .DW(DW), .BW(BW), .IW(IW), .UW(UW)) tgt_if ();
  hci_mem_intf #(.AW(AW), .DW(DW), .BW(BW), .IW(IW), .UW(UW)) ini_if ();

  hci_mem_req_spill #(
    .AW(AW), .DW(DW), .BW(BW), .IW(IW), .UW(UW)
  ) dut (
    .clk_i          (clk),
    .clear_i        (clear),
    .tcdm_target    (tgt_if.target),
    .tcdm_r_valid_o (r_valid),
    .tcdm_initiator (ini_if.initiator),
    .occupancy_o    (occ)
  );

  always #5 clk = ~clk;

  assign ini_if.gnt = mem_gnt;

  // Memory returns the address as read data one cycle after a handshake.
  always @(posedge clk) begin
    if (ini_if.req && ini_if.gnt) begin
      ini_if.r_data <= ini_if.add;
      ini_if.r_id   <= ini_if.id;
      ini_if.r_user <= ini_if.user;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [31:0] a,
                     input logic w, input logic [31:0] d,
                     input logic [3:0] b, input logic [7:0] i);
    tgt_if.req  = r;
    tgt_if.add  = a;
    tgt_if.wen  = w;
    tgt_if.data = d;
    tgt_if.be   = b;
    tgt_if.id   = i;
    tgt_if.user = i[0];
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 8'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    req_t e;
    req_t got;
    chk("r_valid", r_valid, exp_rv);
    if (r_valid) begin
      chk("resp_pending", resp_q.size() > 0, 1);
      if (resp_q.size() > 0) begin
        e = resp_q.pop_front();
        chk("r_id", tgt_if.r_id, e.id);
        chk("r_data", tgt_if.r_data, e.add);
        chk("r_user", tgt_if.r_user, e.user);
      end
    end
    if (clear) begin
      req_q.delete();
      resp_q.delete();
      exp_rv = 1'b0;
    end else begin
      if (tgt_if.req && tgt_if.gnt)
        req_q.push_back({tgt_if.add, tgt_if.wen, tgt_if.data,
                         tgt_if.be, tgt_if.id, tgt_if.user});
      exp_rv = ini_if.req && ini_if.gnt;
      if (exp_rv) begin
        got = {ini_if.add, ini_if.wen, ini_if.data,
               ini_if.be, ini_if.id, ini_if.user};
        chk("dn_expected", req_q.size() > 0, 1);
        if (req_q.size() > 0) begin
          e = req_q.pop_front();
          chk("dn_req", got, e);
          resp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    clear = 1'b1;
    mem_gnt = 1'b1;
    drv(1'b1, 32'h999, 1'b1, 32'h0, 4'hf, 8'hff);
    repeat (2) begin
      step();
      chk("rst_gnt", tgt_if.gnt, 1);
      chk("rst_dreq", ini_if.req, 0);
      chk("rst_occ", occ, 0);
      chk("rst_rv", r_valid, 0);
    end
    clear = 1'b0;
    step();
    chk("rel_occ", occ, 1);
    chk("rel_dreq", ini_if.req, 1);
    idle();
    step();
    chk("rel_drain", occ, 0);
    chk("rel_rv", r_valid, 1);

    // back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'h0, 4'hf, 8'(i));
      step();
      chk("st_occ", occ, 1);
      chk("st_dreq", ini_if.req, 1);
      chk("st_gnt", tgt_if.gnt, 1);
      chk("st_dadd", ini_if.add, 32'h100 + 32'(4 * i));
      chk("st_rv", r_valid, i > 0);
    end
    idle();
    step();
    chk("st_end_occ", occ, 0);
    chk("st_end_rv", r_valid, 1);
    step();
    chk("st_end_rv0", r_valid, 0);

    // downstream stall with writes A, B, C
    mem_gnt = 1'b0;
    drv(1'b1, 32'h200, 1'b0, 32'hA0A0, 4'hf, 8'h20);
    step();
    chk("sl_occ1", occ, 1);
    chk("sl_gnt1", tgt_if.gnt, 1);
    drv(1'b1, 32'h204, 1'b0, 32'hB0B0, 4'hf, 8'h21);
    step();
    chk("sl_occ2", occ, 2);
    chk("sl_gnt0", tgt_if.gnt, 0);
    drv(1'b1, 32'h208, 1'b0, 32'hC0C0, 4'hf, 8'h22);
    repeat (3) begin
      step();
      chk("sl_hold_occ", occ, 2);
      chk("sl_hold_gnt", tgt_if.gnt, 0);
      chk("sl_hold_add", ini_if.add, 32'h200);
      chk("sl_hold_data", ini_if.data, 32'hA0A0);
    end
    mem_gnt = 1'b1;
    step();
    chk("sl_pop_occ", occ, 1);
    chk("sl_pop_gnt", tgt_if.gnt, 1);
    chk("sl_pop_add", ini_if.add, 32'h204);
    step();
    chk("sl_c_occ", occ, 1);
    chk("sl_c_add", ini_if.add, 32'h208);
    idle();
    step();
    chk("sl_end_occ", occ, 0);

    // pop at full, refill next cycle
    mem_gnt = 1'b0;
    drv(1'b1, 32'h300, 1'b1, 32'h0, 4'hf, 8'h30);
    step();
    drv(1'b1, 32'h304, 1'b1, 32'h0, 4'hf, 8'h31);
    step();
    chk("fp_occ2", occ, 2);
    drv(1'b1, 32'h308, 1'b1, 32'h0, 4'hf, 8'h32);
    mem_gnt = 1'b1;
    step();
    chk("fp_occ1", occ, 1);
    chk("fp_gnt1", tgt_if.gnt, 1);
    chk("fp_add", ini_if.add, 32'h304);
    mem_gnt = 1'b0;
    step();
    chk("fp_refill", occ, 2);
    chk("fp_gnt0", tgt_if.gnt, 0);
    idle();
    mem_gnt = 1'b1;
    step();
    chk("fp_d1", occ, 1);
    chk("fp_d1_add", ini_if.add, 32'h308);
    step();
    chk("fp_d0", occ, 0);

    // clear with two buffered and a handshake in flight
    mem_gnt = 1'b0;
    drv(1'b1, 32'h400, 1'b1, 32'h0, 4'hf, 8'h40);
    step();
    drv(1'b1, 32'h404, 1'b1, 32'h0, 4'hf, 8'h41);
    step();
    chk("cl_occ2", occ, 2);
    idle();
    mem_gnt = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("cl_occ", occ, 0);
    chk("cl_dreq", ini_if.req, 0);
    chk("cl_rv", r_valid, 0);
    chk("cl_gnt", tgt_if.gnt, 1);
    step();
    chk("cl_dreq2", ini_if.req, 0);
    chk("cl_rv2", r_valid, 0);

    // write then read of the same word
    drv(1'b1, 32'h40, 1'b0, 32'hDEADBEEF, 4'b0101, 8'h51);
    step();
    chk("mx_wen0", ini_if.wen, 0);
    chk("mx_be", ini_if.be, 4'b0101);
    chk("mx_data", ini_if.data, 32'hDEADBEEF);
    drv(1'b1, 32'h40, 1'b1, 32'h0, 4'hf, 8'h52);
    step();
    chk("mx_wen1", ini_if.wen, 1);
    chk("mx_radd", ini_if.add, 32'h40);
    chk("mx_rv_w", r_valid, 1);
    chk("mx_rid_w", tgt_if.r_id, 8'h51);
    idle();
    step();
    chk("mx_rv_r", r_valid, 1);
    chk("mx_rid_r", tgt_if.r_id, 8'h52);
    step();
    chk("mx_rv0", r_valid, 0);

    step();
    chk("sb_req_empty", req_q.size(), 0);
    chk("sb_resp_empty", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
